min_receive_fsm: RTL and testbench

MIN_RECEIVE_FSM -- requirements
Module: min_receive_fsm

---
 rtl/min_pkg.sv | 23 ++
 rtl/crc32_byte.sv | 21 ++
 rtl/min_receive_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_min_receive_fsm.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/min_pkg.sv
// Shared definitions for the MIN frame receiver and transmitter:
// framing byte values, CRC32 constants and the frame state enumeration.
package min_pkg;

  localparam logic [7:0]  SOF_BYTE   = 8'hAA;
  localparam logic [7:0]  EOF_BYTE   = 8'h55;
  localparam logic [7:0]  STUFF_BYTE = 8'h55;

  // Reflected CRC32 (IEEE 802.3) parameters.
  localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_ID,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC,
    ST_EOF
  } min_state_e;

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte update of a reflected CRC32 register
// (LSB-first, polynomial CRC_POLY). No final XOR is applied here.
module crc32_byte
  import min_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Fold the byte in, then run eight bit-serial division steps.
  always_comb begin
    logic [31:0] c;
    c = crc_i ^ {24'h0, data_i};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/min_receive_fsm.sv
// MIN frame receiver: hunts for the AA AA AA start marker, removes byte
// stuffing, collects ID, length, payload and CRC, and reports each frame
// as accepted (o_valid) or discarded (o_err).
// Build option: define MIN_RX_CRC_EN to check the received CRC32; without
// it the CRC bytes are consumed and every CRC is treated as good.
module min_receive_fsm
  import min_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 4,
  parameter int unsigned ID_WIDTH    = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  output logic                     o_valid,
  output logic [ID_WIDTH-1:0]      o_id,
  output logic [7:0]               o_len,
  output logic [8*MAX_PAYLOAD-1:0] o_data,
  output logic                     o_err,
  output logic                     o_busy
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  min_state_e                       state_q, state_d;
  logic [1:0]                       aa_cnt_q, aa_cnt_d;
  logic [7:0]                       idx_q, idx_d;
  logic [7:0]                       len_q, len_d;
  logic [ID_WIDTH-1:0]              id_q, id_d;
  // Element MAX_PAYLOAD-1 sits in the MSBs and holds the first payload byte.
  logic [MAX_PAYLOAD-1:0][7:0]      pay_q, pay_d;
  logic                             valid_q, valid_d;
  logic                             err_q, err_d;
  logic [ID_WIDTH-1:0]              out_id_q, out_id_d;
  logic [7:0]                       out_len_q, out_len_d;
  logic [8*MAX_PAYLOAD-1:0]         out_data_q, out_data_d;
  logic                             take;
  logic                             crc_ok;

  assign take = i_en & i_valid;

`ifdef MIN_RX_CRC_EN
  logic [31:0] crc_q, crc_d, crc_next;
  logic [31:0] rx_crc_q, rx_crc_d;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (i_data),
    .crc_o  (crc_next)
  );

  assign crc_ok = ((crc_q ^ CRC_XOROUT) == rx_crc_q);
`else
  assign crc_ok = 1'b1;
`endif

  // Next-state and output decode for one accepted byte.
  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    aa_cnt_d   = aa_cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    id_d       = id_q;
    pay_d      = pay_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    out_id_d   = out_id_q;
    out_len_d  = out_len_q;
    out_data_d = out_data_q;
`ifdef MIN_RX_CRC_EN
    crc_d      = crc_q;
    rx_crc_d   = rx_crc_q;
`endif

    if (take) begin
      if (i_data == SOF_BYTE && aa_cnt_q == 2'd2) begin
        // Third AA in a row: a new frame starts, whatever was in progress.
        state_d  = ST_ID;
        aa_cnt_d = 2'd0;
        idx_d    = 8'd0;
        pay_d    = '0;
`ifdef MIN_RX_CRC_EN
        crc_d    = CRC_INIT;
`endif
      end else if (i_data == STUFF_BYTE && aa_cnt_q == 2'd2 && state_q != ST_SEARCH) begin
        // Stuff byte inserted by the sender after AA AA: discard it.
        aa_cnt_d = 2'd0;
      end else begin
        aa_cnt_d = (i_data == SOF_BYTE) ? aa_cnt_q + 2'd1 : 2'd0;
        unique case (state_q)
          ST_SEARCH: state_d = ST_SEARCH;
          ST_ID: begin
            id_d    = i_data[ID_WIDTH-1:0];
            state_d = ST_LEN;
`ifdef MIN_RX_CRC_EN
            crc_d   = crc_next;
`endif
          end
          ST_LEN: begin
            len_d = i_data;
            idx_d = 8'd0;
`ifdef MIN_RX_CRC_EN
            crc_d = crc_next;
`endif
            if (i_data > MAX_LEN) begin
              err_d   = 1'b1;
              state_d = ST_SEARCH;
            end else if (i_data == 8'd0) begin
              state_d = ST_CRC;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            for (int k = 0; k < int'(MAX_PAYLOAD); k++) begin
              if (idx_q == 8'(int'(MAX_PAYLOAD) - 1 - k)) pay_d[k] = i_data;
            end
`ifdef MIN_RX_CRC_EN
            crc_d = crc_next;
`endif
            idx_d = idx_q + 8'd1;
            if (idx_q + 8'd1 == len_q) begin
              state_d = ST_CRC;
              idx_d   = 8'd0;
            end
          end
          ST_CRC: begin
`ifdef MIN_RX_CRC_EN
            rx_crc_d = {rx_crc_q[23:0], i_data};
`endif
            idx_d = idx_q + 8'd1;
            if (idx_q == 8'd3) begin
              state_d = ST_EOF;
              idx_d   = 8'd0;
            end
          end
          ST_EOF: begin
            if (i_data == EOF_BYTE && crc_ok) begin
              valid_d    = 1'b1;
              out_id_d   = id_q;
              out_len_d  = len_q;
              out_data_d = pay_q;
            end else begin
              err_d = 1'b1;
            end
            state_d = ST_SEARCH;
          end
          default: state_d = ST_SEARCH;
        endcase
      end
    end
  end

  // State, frame buffer and output registers.
  // NOTE: the payload buffer is reset along with the control state so o_data is zero out of reset and unused bytes read as zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_SEARCH;
      aa_cnt_q   <= 2'd0;
      idx_q      <= 8'd0;
      len_q      <= 8'd0;
      id_q       <= '0;
      pay_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      out_id_q   <= '0;
      out_len_q  <= 8'd0;
      out_data_q <= '0;
`ifdef MIN_RX_CRC_EN
      crc_q      <= CRC_INIT;
      rx_crc_q   <= 32'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      aa_cnt_q   <= aa_cnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      id_q       <= id_d;
      pay_q      <= pay_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      out_id_q   <= out_id_d;
      out_len_q  <= out_len_d;
      out_data_q <= out_data_d;
`ifdef MIN_RX_CRC_EN
      crc_q      <= crc_d;
      rx_crc_q   <= rx_crc_d;
`endif
    end
  end

  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_id    = out_id_q;
  assign o_len   = out_len_q;
  assign o_data  = out_data_q;
  assign o_busy  = (state_q != ST_SEARCH);

endmodule

// File: tb/tb_min_receive_fsm.sv
// Directed bench for min_receive_fsm. Stimulus pushes the expected frame
// outcome into a queue; a monitor pops and compares on every o_valid/o_err.
module tb_min_receive_fsm;

  localparam int MAXP = 4;
  localparam int IDW  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              vld;
  logic [7:0]        data;
  logic              o_valid, o_err, o_busy;
  logic [IDW-1:0]    o_id;
  logic [7:0]        o_len;
  logic [8*MAXP-1:0] o_data;

  always #5 clk = ~clk;

  min_receive_fsm #(.MAX_PAYLOAD(MAXP), .ID_WIDTH(IDW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_valid (vld),
    .i_data  (data),
    .o_valid (o_valid),
    .o_id    (o_id),
    .o_len   (o_len),
    .o_data  (o_data),
    .o_err   (o_err),
    .o_busy  (o_busy)
  );

  typedef struct {
    bit             is_valid;
    logic [IDW-1:0] id;
    logic [7:0]     len;
    logic [31:0]    data;
  } exp_t;

  exp_t           sb_q[$];
  int             total = 0;
  int             bad   = 0;
  logic [IDW-1:0] last_id   = '0;
  logic [7:0]     last_len  = '0;
  logic [31:0]    last_data = '0;
  logic [7:0]     pl [MAXP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic exp_valid(input logic [7:0] id, input logic [7:0] len, input logic [31:0] d);
    exp_t e;
    e.is_valid = 1'b1;
    e.id       = id[IDW-1:0];
    e.len      = len;
    e.data     = d;
    sb_q.push_back(e);
    last_id   = e.id;
    last_len  = len;
    last_data = d;
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_valid = 1'b0;
    e.id       = last_id;
    e.len      = last_len;
    e.data     = last_data;
    sb_q.push_back(e);
  endtask

  // Each byte: one idle cycle, then a one-cycle strobe. Returns 1 time unit
  // after the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    data = b;
    vld  = 1'b1;
    @(posedge clk); #1;
    vld  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] len,
                            input logic [7:0] p [MAXP], input int np,
                            input bit sof, input bit bad_crc, input bit bad_eof);
    logic [7:0]  raw[$];
    logic [31:0] c;
    int          cnt;
    raw.push_back(id);
    raw.push_back(len);
    for (int i = 0; i < np; i++) raw.push_back(p[i]);
    c = 32'hFFFFFFFF;
    foreach (raw[i]) c = crc_step(c, raw[i]);
    c = ~c;
    if (bad_crc) c[0] = ~c[0];
    raw.push_back(c[31:24]);
    raw.push_back(c[23:16]);
    raw.push_back(c[15:8]);
    raw.push_back(c[7:0]);
    if (sof) repeat (3) send_byte(8'hAA);
    cnt = 0;
    foreach (raw[i]) begin
      send_byte(raw[i]);
      cnt = (raw[i] == 8'hAA) ? cnt + 1 : 0;
      if (cnt == 2) begin
        send_byte(8'h55);
        cnt = 0;
      end
    end
    send_byte(bad_eof ? 8'h56 : 8'h55);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (o_valid || o_err)) begin
      check("valid_err_exclusive", 64'(o_valid & o_err), 64'd0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b expected no event", o_valid, o_err);
      end else begin
        e = sb_q.pop_front();
        check("event_valid", 64'(o_valid), 64'(e.is_valid));
        check("event_err", 64'(o_err), 64'(!e.is_valid));
        check("o_id", 64'(o_id), 64'(e.id));
        check("o_len", 64'(o_len), 64'(e.len));
        check("o_data", 64'(o_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    vld   = 1'b0;
    data  = 8'h00;
    #2;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_id", 64'(o_id), 64'd0);
    check("rst_len", 64'(o_len), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Good frame at maximum length.
    pl = '{8'h12, 8'h34, 8'h56, 8'h78};
    exp_valid(8'h08, 8'h04, 32'h12345678);
    send_frame(8'h08, 8'h04, pl, 4, 1'b1, 1'b0, 1'b0);

    // Payload AA AA 01 02 goes out as AA AA 55 01 02.
    pl = '{8'hAA, 8'hAA, 8'h01, 8'h02};
    exp_valid(8'h21, 8'h04, 32'hAAAA0102);
    send_frame(8'h21, 8'h04, pl, 4, 1'b1, 1'b0, 1'b0);

    // Corrupted CRC.
    pl = '{8'h01, 8'h02, 8'h03, 8'h00};
`ifdef MIN_RX_CRC_EN
    exp_err();
`else
    exp_valid(8'h05, 8'h03, 32'h01020300);
`endif
    send_frame(8'h05, 8'h03, pl, 3, 1'b1, 1'b1, 1'b0);

    // Oversize length.
    exp_err();
    repeat (3) send_byte(8'hAA);
    send_byte(8'h08);
    check("busy_in_len", 64'(o_busy), 64'd1);
    send_byte(8'h05);
    check("oversize_busy", 64'(o_busy), 64'd0);
    check("oversize_err", 64'(o_err), 64'd1);

    // Zero-length frame; ID byte upper bits dropped (0xC7 -> 0x07).
    exp_valid(8'h07, 8'h00, 32'h00000000);
    send_frame(8'hC7, 8'h00, pl, 0, 1'b1, 1'b0, 1'b0);

    // Wrong end-of-frame byte.
    pl = '{8'h9A, 8'hBC, 8'h00, 8'h00};
    exp_err();
    send_frame(8'h01, 8'h02, pl, 2, 1'b1, 1'b0, 1'b1);

    // Restart after the second payload byte, then the rest of a good frame.
    exp_valid(8'h12, 8'h04, 32'hCAFEBEEF);
    repeat (3) send_byte(8'hAA);
    send_byte(8'h11);
    send_byte(8'h04);
    send_byte(8'hDE);
    send_byte(8'hAD);
    repeat (3) send_byte(8'hAA);
    pl = '{8'hCA, 8'hFE, 8'hBE, 8'hEF};
    send_frame(8'h12, 8'h04, pl, 4, 1'b0, 1'b0, 1'b0);

    // Bytes strobed while disabled are ignored.
    exp_valid(8'h2A, 8'h02, 32'h5A5B0000);
    repeat (3) send_byte(8'hAA);
    en = 1'b0;
    send_byte(8'h99);
    send_byte(8'h99);
    check("busy_while_disabled", 64'(o_busy), 64'd1);
    en = 1'b1;
    pl = '{8'h5A, 8'h5B, 8'h00, 8'h00};
    send_frame(8'h2A, 8'h02, pl, 2, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the payload.
    repeat (3) send_byte(8'hAA);
    send_byte(8'h08);
    send_byte(8'h04);
    send_byte(8'h12);
    check("busy_mid_payload", 64'(o_busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(o_busy), 64'd0);
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_err", 64'(o_err), 64'd0);
    check("arst_id", 64'(o_id), 64'd0);
    check("arst_len", 64'(o_len), 64'd0);
    check("arst_data", 64'(o_data), 64'd0);
    last_id   = '0;
    last_len  = '0;
    last_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Stream resumes mid-frame; only the next AA AA AA resynchronises.
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'hAA);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h78);
    check("resync_idle", 64'(o_busy), 64'd0);
    pl = '{8'h77, 8'h00, 8'h00, 8'h00};
    exp_valid(8'h33, 8'h01, 32'h77000000);
    send_frame(8'h33, 8'h01, pl, 1, 1'b1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
